// File: rtl/pipe_wb_reg.sv
// Memory-to-Writeback pipeline register for the Y86-64 pipeline.
// Supports stall/bubble control, a sticky conflict flag and saturating stall/bubble counters.
module pipe_wb_reg #(
    parameter int unsigned         DATA_W    = 64,
    parameter int unsigned         STAT_W    = 3,
    parameter int unsigned         ICODE_W   = 4,
    parameter int unsigned         REG_W     = 4,
    parameter int unsigned         CNT_W     = 16,
    parameter logic [ICODE_W-1:0]  NOP_ICODE = ICODE_W'(4'h1),
    parameter logic [STAT_W-1:0]   BUB_STAT  = STAT_W'(3'd1),
    parameter logic [REG_W-1:0]    RNONE     = REG_W'(4'hF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               W_stall,
    input  logic               W_bubble,
    input  logic               cnt_clr,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [ICODE_W-1:0] m_icode,
    input  logic [DATA_W-1:0]  m_valE,
    input  logic [DATA_W-1:0]  m_valM,
    input  logic [REG_W-1:0]   m_dstE,
    input  logic [REG_W-1:0]   m_dstM,
    input  logic               m_valid,
    output logic [STAT_W-1:0]  W_stat,
    output logic [ICODE_W-1:0] W_icode,
    output logic [DATA_W-1:0]  W_valE,
    output logic [DATA_W-1:0]  W_valM,
    output logic [REG_W-1:0]   W_dstE,
    output logic [REG_W-1:0]   W_dstM,
    output logic               W_valid,
    output logic               conflict_err,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [ICODE_W-1:0] icode;
        logic [DATA_W-1:0]  val_e;
        logic [DATA_W-1:0]  val_m;
        logic [REG_W-1:0]   dst_e;
        logic [REG_W-1:0]   dst_m;
    } wb_t;

    localparam wb_t             BUBBLE  = '{stat: BUB_STAT, icode: NOP_ICODE,
                                            val_e: '0, val_m: '0,
                                            dst_e: RNONE, dst_m: RNONE};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    wb_t              r_wb;
    logic             r_valid;
    logic             r_conflict;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    wb_t              w_m;
    logic             w_bubble_load;

    assign w_m           = '{stat: m_stat, icode: m_icode, val_e: m_valE,
                             val_m: m_valM, dst_e: m_dstE, dst_m: m_dstM};
    assign w_bubble_load = W_bubble & ~W_stall;

    // Pipeline fields: stall holds, bubble loads a NOP, otherwise capture the M stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb    <= BUBBLE;
            r_valid <= 1'b0;
        end else if (W_stall) begin
            r_wb    <= r_wb;
            r_valid <= r_valid;
        end else if (W_bubble) begin
            r_wb    <= BUBBLE;
            r_valid <= 1'b0;
        end else begin
            r_wb    <= w_m;
            r_valid <= m_valid;
        end
    end

    // Sticky flag: only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict <= 1'b0;
        end else if (W_stall && W_bubble) begin
            r_conflict <= 1'b1;
        end
    end

    // Saturating counters; a clear takes precedence over any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (W_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_bubble_load && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign W_stat       = r_wb.stat;
    assign W_icode      = r_wb.icode;
    assign W_valE       = r_wb.val_e;
    assign W_valM       = r_wb.val_m;
    assign W_dstE       = r_wb.dst_e;
    assign W_dstM       = r_wb.dst_m;
    assign W_valid      = r_valid;
    assign conflict_err = r_conflict;
    assign stall_cnt    = r_stall_cnt;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_wb_reg.sv
// Directed bench for pipe_wb_reg with 3-bit counters so saturation is reachable.
module tb_pipe_wb_reg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned STAT_W  = 3;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned CNT_W   = 3;

    logic               clk;
    logic               rst_n;
    logic               W_stall;
    logic               W_bubble;
    logic               cnt_clr;
    logic [STAT_W-1:0]  m_stat;
    logic [ICODE_W-1:0] m_icode;
    logic [DATA_W-1:0]  m_valE;
    logic [DATA_W-1:0]  m_valM;
    logic [REG_W-1:0]   m_dstE;
    logic [REG_W-1:0]   m_dstM;
    logic               m_valid;
    logic [STAT_W-1:0]  W_stat;
    logic [ICODE_W-1:0] W_icode;
    logic [DATA_W-1:0]  W_valE;
    logic [DATA_W-1:0]  W_valM;
    logic [REG_W-1:0]   W_dstE;
    logic [REG_W-1:0]   W_dstM;
    logic               W_valid;
    logic               conflict_err;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   bubble_cnt;

    int vectors;
    int miscompares;

    pipe_wb_reg #(
        .DATA_W (DATA_W),
        .STAT_W (STAT_W),
        .ICODE_W(ICODE_W),
        .REG_W  (REG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .W_stall     (W_stall),
        .W_bubble    (W_bubble),
        .cnt_clr     (cnt_clr),
        .m_stat      (m_stat),
        .m_icode     (m_icode),
        .m_valE      (m_valE),
        .m_valM      (m_valM),
        .m_dstE      (m_dstE),
        .m_dstM      (m_dstM),
        .m_valid     (m_valid),
        .W_stat      (W_stat),
        .W_icode     (W_icode),
        .W_valE      (W_valE),
        .W_valM      (W_valM),
        .W_dstE      (W_dstE),
        .W_dstM      (W_dstM),
        .W_valid     (W_valid),
        .conflict_err(conflict_err),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                           input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm,
                           input logic vld);
        m_stat  = st;
        m_icode = ic;
        m_valE  = ve;
        m_valM  = vm;
        m_dstE  = de;
        m_dstM  = dm;
        m_valid = vld;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".stat"},  64'(W_stat),  64'd1);
        chk({tag, ".icode"}, 64'(W_icode), 64'h1);
        chk({tag, ".valE"},  W_valE,       64'd0);
        chk({tag, ".valM"},  W_valM,       64'd0);
        chk({tag, ".dstE"},  64'(W_dstE),  64'hF);
        chk({tag, ".dstM"},  64'(W_dstM),  64'hF);
        chk({tag, ".valid"}, 64'(W_valid), 64'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        W_stall     = 1'b0;
        W_bubble    = 1'b0;
        cnt_clr     = 1'b0;
        drive_m(3'd0, 4'h0, 64'd0, 64'd0, 4'h0, 4'h0, 1'b0);

        // Power-on reset values
        step();
        step();
        chk_bubble("por");
        chk("por.conflict", 64'(conflict_err), 64'd0);
        chk("por.stall_cnt", 64'(stall_cnt), 64'd0);
        chk("por.bubble_cnt", 64'(bubble_cnt), 64'd0);

        // Pass-through with one-cycle latency
        rst_n = 1'b1;
        drive_m(3'd1, 4'h3, 64'h1234, 64'h5555_0000_0000_0001, 4'h2, 4'h7, 1'b1);
        step();
        chk("pass.stat",  64'(W_stat),  64'd1);
        chk("pass.icode", 64'(W_icode), 64'h3);
        chk("pass.valE",  W_valE,       64'h1234);
        chk("pass.valM",  W_valM,       64'h5555_0000_0000_0001);
        chk("pass.dstE",  64'(W_dstE),  64'h2);
        chk("pass.dstM",  64'(W_dstM),  64'h7);
        chk("pass.valid", 64'(W_valid), 64'd1);

        // Mid-cycle asynchronous reset takes effect without a clock edge
        #3;
        rst_n = 1'b0;
        #1;
        chk_bubble("async_rst");
        rst_n = 1'b1;

        // Stall hold for 3 edges while M changes
        drive_m(3'd1, 4'h6, 64'hAA, 64'h0, 4'h3, 4'h4, 1'b1);
        step();
        chk("load6.icode", 64'(W_icode), 64'h6);
        W_stall = 1'b1;
        drive_m(3'd1, 4'h5, 64'hBB, 64'h0, 4'h3, 4'h4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.icode", 64'(W_icode), 64'h6);
            chk("stall.valE",  W_valE,       64'hAA);
            chk("stall.valid", 64'(W_valid), 64'd1);
            chk("stall.cnt",   64'(stall_cnt), 64'(i + 1));
        end
        W_stall = 1'b0;
        step();
        chk("unstall.icode", 64'(W_icode), 64'h5);
        chk("unstall.valE",  W_valE,       64'hBB);
        chk("unstall.cnt",   64'(stall_cnt), 64'd3);
        chk("unstall.bcnt",  64'(bubble_cnt), 64'd0);

        // Bubble injection overrides a valid M instruction
        W_bubble = 1'b1;
        drive_m(3'd4, 4'h5, 64'hCC, 64'hDD, 4'h2, 4'h3, 1'b1);
        step();
        chk_bubble("bubble");
        chk("bubble.bcnt", 64'(bubble_cnt), 64'd1);
        chk("bubble.scnt", 64'(stall_cnt),  64'd3);

        // Normal load, then stall+bubble conflict
        W_bubble = 1'b0;
        drive_m(3'd1, 4'h7, 64'h77, 64'h0, 4'h5, 4'h6, 1'b1);
        step();
        chk("load7.icode", 64'(W_icode), 64'h7);
        chk("load7.conflict", 64'(conflict_err), 64'd0);
        W_stall  = 1'b1;
        W_bubble = 1'b1;
        drive_m(3'd1, 4'h2, 64'h22, 64'h0, 4'h1, 4'h1, 1'b1);
        step();
        chk("conf.icode",    64'(W_icode), 64'h7);
        chk("conf.valE",     W_valE,       64'h77);
        chk("conf.valid",    64'(W_valid), 64'd1);
        chk("conf.flag",     64'(conflict_err), 64'd1);
        chk("conf.scnt",     64'(stall_cnt),  64'd4);
        chk("conf.bcnt",     64'(bubble_cnt), 64'd1);

        // Conflict flag is sticky across normal traffic
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_m(3'd1, 4'(i), 64'(i * 3), 64'h0, 4'h1, 4'h2, 1'b1);
            step();
            chk("sticky.flag",  64'(conflict_err), 64'd1);
            chk("sticky.icode", 64'(W_icode), 64'(i));
        end
        chk("sticky.scnt", 64'(stall_cnt), 64'd4);

        // Stall counter saturates at 7
        W_stall = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("sat.scnt", 64'(stall_cnt), (4 + i > 7) ? 64'd7 : 64'(4 + i));
        end
        chk("sat.icode", 64'(W_icode), 64'h9);

        // Clear wins over simultaneous stall increment
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr.scnt",     64'(stall_cnt),  64'd0);
        chk("clr.bcnt",     64'(bubble_cnt), 64'd0);
        chk("clr.conflict", 64'(conflict_err), 64'd1);
        chk("clr.icode",    64'(W_icode), 64'h9);

        // Reset during stall with nonzero counters
        W_stall  = 1'b0;
        W_bubble = 1'b1;
        step();
        W_bubble = 1'b0;
        W_stall  = 1'b1;
        step();
        step();
        chk("pre_rst.scnt", 64'(stall_cnt),  64'd2);
        chk("pre_rst.bcnt", 64'(bubble_cnt), 64'd1);
        drive_m(3'd2, 4'hA, 64'hABCD, 64'h1111, 4'h3, 4'h4, 1'b1);
        W_stall = 1'b0;
        step();
        chk("pre_rst.icode", 64'(W_icode), 64'hA);
        W_stall = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk_bubble("rst_stall");
        chk("rst_stall.scnt",     64'(stall_cnt),  64'd0);
        chk("rst_stall.bcnt",     64'(bubble_cnt), 64'd0);
        chk("rst_stall.conflict", 64'(conflict_err), 64'd0);
        rst_n   = 1'b1;
        W_stall = 1'b0;

        // First edge after reset is a normal update
        step();
        chk("post_rst.icode",    64'(W_icode), 64'hA);
        chk("post_rst.valM",     W_valM,       64'h1111);
        chk("post_rst.conflict", 64'(conflict_err), 64'd0);

        // Bubble counter saturates at 7
        W_bubble = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("bsat.bcnt", 64'(bubble_cnt), (i > 7) ? 64'd7 : 64'(i));
        end
        chk("bsat.scnt", 64'(stall_cnt), 64'd0);
        W_bubble = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
